stream_fifo_flex: RTL and testbench

STREAM_FIFO_FLEX -- requirements
Module: stream_fifo_flex

---
 rtl/stream_fifo_flex.sv | 126 ++++++++++++
 tb/tb_stream_fifo_flex.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo_flex.sv
// stream_fifo_flex: single-clock valid/ready FIFO with a parameterised depth,
// optional first-word fall-through bypass, and almost-full/almost-empty flags
// decoded from the stored entry count.
module stream_fifo_flex #(
  parameter int DATA_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int FALL_THROUGH = 0,
  parameter int AF_TH        = FIFO_DEPTH - 1,
  parameter int AE_TH        = 1,
  localparam int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [CNT_W-1:0]      usage_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF = CNT_W'(AF_TH);
  localparam logic [CNT_W-1:0] CNT_AE = CNT_W'(AE_TH);

  // Reject illegal parameter combinations while elaborating.
  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("stream_fifo_flex: FIFO_DEPTH must be >= 1");
  end
  if (AF_TH < 1 || AF_TH > FIFO_DEPTH) begin : g_bad_af
    $error("stream_fifo_flex: AF_TH must be in 1..FIFO_DEPTH");
  end
  if (AE_TH < 0 || AE_TH > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("stream_fifo_flex: AE_TH must be in 0..FIFO_DEPTH-1");
  end
  if (FALL_THROUGH != 0 && FALL_THROUGH != 1) begin : g_bad_ft
    $error("stream_fifo_flex: FALL_THROUGH must be 0 or 1");
  end

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      usage_q, usage_d;

  logic empty;
  logic full;
  logic push;
  logic pop;
  logic bypass;
  logic store;
  logic take;

  // Handshake outputs, bypass decision and next-state for pointers and count.
  always_comb begin
    empty = (usage_q == '0);
    full  = (usage_q == CNT_FULL);

    w_ready_o = !full && !flush_i;
    if (FALL_THROUGH != 0) begin
      r_valid_o = (!empty || w_valid_i) && !flush_i;
      r_data_o  = empty ? w_data_i : mem_q[rd_ptr_q];
    end else begin
      r_valid_o = !empty && !flush_i;
      r_data_o  = mem_q[rd_ptr_q];
    end

    push   = w_valid_i && w_ready_o;
    pop    = r_valid_o && r_ready_i;
    bypass = (FALL_THROUGH != 0) && empty && push && pop;
    store  = push && !bypass;
    take   = pop && !bypass;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    usage_d  = usage_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      if (store) begin
        wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (take) begin
        rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (store && !take) begin
        usage_d = usage_q + CNT_W'(1);
      end else if (take && !store) begin
        usage_d = usage_q - CNT_W'(1);
      end
    end

    usage_o        = usage_q;
    almost_full_o  = (usage_q >= CNT_AF);
    almost_empty_o = (usage_q <= CNT_AE);
  end

  // Pointer and count registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
    end
  end

  // Payload storage is left unreset; only accepted, non-bypassed writes land here.
  always_ff @(posedge clk) begin
    if (!rst && store) begin
      mem_q[wr_ptr_q] <= w_data_i;
    end
  end

endmodule

// File: tb/tb_stream_fifo_flex.sv
// Directed bench for stream_fifo_flex: a depth-4 registered FIFO driven from a
// vector table, plus hand sequences for depth-3 wrap, fall-through bypass and
// mid-operation reset.
module tb_stream_fifo_flex;

  typedef struct {
    logic       flush;
    logic       w_valid;
    logic [7:0] w_data;
    logic       r_ready;
    logic       e_w_ready;
    logic       e_r_valid;
    logic [7:0] e_r_data;
    logic       chk_data;
    logic [2:0] e_usage;
    logic       e_af;
    logic       e_ae;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Depth 4, registered mode
  logic       a_flush = 0, a_w_valid = 0, a_r_ready = 0;
  logic [7:0] a_w_data = 0;
  logic       a_w_ready, a_r_valid, a_af, a_ae;
  logic [7:0] a_r_data;
  logic [2:0] a_usage;

  // Depth 3, registered mode
  logic       b_flush = 0, b_w_valid = 0, b_r_ready = 0;
  logic [7:0] b_w_data = 0;
  logic       b_w_ready, b_r_valid, b_af, b_ae;
  logic [7:0] b_r_data;
  logic [1:0] b_usage;

  // Depth 4, fall-through mode
  logic       f_flush = 0, f_w_valid = 0, f_r_ready = 0;
  logic [7:0] f_w_data = 0;
  logic       f_w_ready, f_r_valid, f_af, f_ae;
  logic [7:0] f_r_data;
  logic [2:0] f_usage;

  int checks = 0;
  int errors = 0;

  vec_t vecs [18];

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  stream_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FALL_THROUGH(0)) u_a (
    .clk(clk), .rst(rst), .flush_i(a_flush),
    .w_valid_i(a_w_valid), .w_ready_o(a_w_ready), .w_data_i(a_w_data),
    .r_valid_o(a_r_valid), .r_ready_i(a_r_ready), .r_data_o(a_r_data),
    .usage_o(a_usage), .almost_full_o(a_af), .almost_empty_o(a_ae)
  );

  stream_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(3), .FALL_THROUGH(0)) u_b (
    .clk(clk), .rst(rst), .flush_i(b_flush),
    .w_valid_i(b_w_valid), .w_ready_o(b_w_ready), .w_data_i(b_w_data),
    .r_valid_o(b_r_valid), .r_ready_i(b_r_ready), .r_data_o(b_r_data),
    .usage_o(b_usage), .almost_full_o(b_af), .almost_empty_o(b_ae)
  );

  stream_fifo_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FALL_THROUGH(1)) u_f (
    .clk(clk), .rst(rst), .flush_i(f_flush),
    .w_valid_i(f_w_valid), .w_ready_o(f_w_ready), .w_data_i(f_w_data),
    .r_valid_o(f_r_valid), .r_ready_i(f_r_ready), .r_data_o(f_r_data),
    .usage_o(f_usage), .almost_full_o(f_af), .almost_empty_o(f_ae)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    a_flush   = v.flush;
    a_w_valid = v.w_valid;
    a_w_data  = v.w_data;
    a_r_ready = v.r_ready;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // flush, wv, wdata, rr | w_ready, r_valid, r_data, chk, usage, af, ae
    vecs[0]  = '{0, 1, 8'hA1, 0, 1, 0, 8'h00, 0, 3'd0, 0, 1};
    vecs[1]  = '{0, 1, 8'hA2, 0, 1, 1, 8'hA1, 1, 3'd1, 0, 1};
    vecs[2]  = '{0, 1, 8'hA3, 0, 1, 1, 8'hA1, 1, 3'd2, 0, 0};
    vecs[3]  = '{0, 1, 8'hA4, 0, 1, 1, 8'hA1, 1, 3'd3, 1, 0};
    vecs[4]  = '{0, 1, 8'hEE, 0, 0, 1, 8'hA1, 1, 3'd4, 1, 0};
    vecs[5]  = '{0, 1, 8'hEF, 1, 0, 1, 8'hA1, 1, 3'd4, 1, 0};
    vecs[6]  = '{0, 0, 8'h00, 1, 1, 1, 8'hA2, 1, 3'd3, 1, 0};
    vecs[7]  = '{0, 0, 8'h00, 1, 1, 1, 8'hA3, 1, 3'd2, 0, 0};
    vecs[8]  = '{0, 0, 8'h00, 1, 1, 1, 8'hA4, 1, 3'd1, 0, 1};
    vecs[9]  = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 3'd0, 0, 1};
    vecs[10] = '{0, 1, 8'hB1, 0, 1, 0, 8'h00, 0, 3'd0, 0, 1};
    vecs[11] = '{0, 1, 8'hB2, 0, 1, 1, 8'hB1, 1, 3'd1, 0, 1};
    vecs[12] = '{0, 1, 8'hB3, 0, 1, 1, 8'hB1, 1, 3'd2, 0, 0};
    vecs[13] = '{1, 1, 8'hCC, 1, 0, 0, 8'h00, 0, 3'd3, 1, 0};
    vecs[14] = '{0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 3'd0, 0, 1};
    vecs[15] = '{0, 1, 8'hDD, 0, 1, 0, 8'h00, 0, 3'd0, 0, 1};
    vecs[16] = '{0, 0, 8'h00, 1, 1, 1, 8'hDD, 1, 3'd1, 0, 1};
    vecs[17] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 3'd0, 0, 1};

    // Reset all three instances and check the idle state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst.usage", 32'(a_usage), 32'd0);
    checkOutput("rst.ae", 32'(a_ae), 32'd1);
    checkOutput("rst.af", 32'(a_af), 32'd0);
    checkOutput("rst.w_ready", 32'(a_w_ready), 32'd1);
    checkOutput("rst.r_valid", 32'(a_r_valid), 32'd0);
    checkOutput("rst.ft_r_valid", 32'(f_r_valid), 32'd0);
    nextCycle();

    // Fill, full refusal, pop-while-full, drain, flush and post-flush push
    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d.w_ready", i), 32'(a_w_ready), 32'(vecs[i].e_w_ready));
      checkOutput($sformatf("v%0d.r_valid", i), 32'(a_r_valid), 32'(vecs[i].e_r_valid));
      checkOutput($sformatf("v%0d.usage", i), 32'(a_usage), 32'(vecs[i].e_usage));
      checkOutput($sformatf("v%0d.af", i), 32'(a_af), 32'(vecs[i].e_af));
      checkOutput($sformatf("v%0d.ae", i), 32'(a_ae), 32'(vecs[i].e_ae));
      if (vecs[i].chk_data) begin
        checkOutput($sformatf("v%0d.r_data", i), 32'(a_r_data), 32'(vecs[i].e_r_data));
      end
      nextCycle();
    end
    a_w_valid = 0;
    a_r_ready = 0;
    a_flush   = 0;

    // Depth 3: preload two entries, then ten simultaneous push/pop cycles
    b_w_valid = 1;
    b_w_data  = 8'h30;
    nextCycle();
    b_w_data  = 8'h31;
    nextCycle();
    for (int i = 0; i < 10; i++) begin
      b_w_valid = 1;
      b_w_data  = 8'(8'h32 + i);
      b_r_ready = 1;
      @(negedge clk);
      checkOutput($sformatf("wrap%0d.r_data", i), 32'(b_r_data), 32'(8'h30 + i));
      checkOutput($sformatf("wrap%0d.usage", i), 32'(b_usage), 32'd2);
      checkOutput($sformatf("wrap%0d.w_ready", i), 32'(b_w_ready), 32'd1);
      checkOutput($sformatf("wrap%0d.af", i), 32'(b_af), 32'd1);
      nextCycle();
    end
    b_w_valid = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput($sformatf("wrapdrain%0d.r_data", i), 32'(b_r_data), 32'(8'h3A + i));
      checkOutput($sformatf("wrapdrain%0d.r_valid", i), 32'(b_r_valid), 32'd1);
      nextCycle();
    end
    @(negedge clk);
    checkOutput("wrapend.r_valid", 32'(b_r_valid), 32'd0);
    checkOutput("wrapend.usage", 32'(b_usage), 32'd0);
    b_r_ready = 0;
    nextCycle();

    // Fall-through: same-cycle bypass leaves storage untouched
    f_w_valid = 1;
    f_w_data  = 8'h55;
    f_r_ready = 1;
    @(negedge clk);
    checkOutput("ft.byp.r_valid", 32'(f_r_valid), 32'd1);
    checkOutput("ft.byp.r_data", 32'(f_r_data), 32'h55);
    checkOutput("ft.byp.usage", 32'(f_usage), 32'd0);
    nextCycle();
    f_w_data  = 8'h66;
    f_r_ready = 0;
    @(negedge clk);
    checkOutput("ft.after_byp.usage", 32'(f_usage), 32'd0);
    checkOutput("ft.ae_byp.ae", 32'(f_ae), 32'd1);
    checkOutput("ft.show66.r_data", 32'(f_r_data), 32'h66);
    nextCycle();
    f_w_data = 8'h67;
    @(negedge clk);
    checkOutput("ft.head.r_data", 32'(f_r_data), 32'h66);
    checkOutput("ft.head.usage", 32'(f_usage), 32'd1);
    nextCycle();
    f_w_valid = 0;
    f_r_ready = 1;
    @(negedge clk);
    checkOutput("ft.pop0.r_data", 32'(f_r_data), 32'h66);
    nextCycle();
    @(negedge clk);
    checkOutput("ft.pop1.r_data", 32'(f_r_data), 32'h67);
    checkOutput("ft.pop1.usage", 32'(f_usage), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("ft.empty.r_valid", 32'(f_r_valid), 32'd0);
    checkOutput("ft.empty.usage", 32'(f_usage), 32'd0);
    f_flush   = 1;
    f_w_valid = 1;
    f_w_data  = 8'h88;
    @(negedge clk);
    checkOutput("ft.flush.r_valid", 32'(f_r_valid), 32'd0);
    checkOutput("ft.flush.w_ready", 32'(f_w_ready), 32'd0);
    nextCycle();
    f_flush   = 0;
    f_w_valid = 0;
    f_r_ready = 0;
    @(negedge clk);
    checkOutput("ft.postflush.usage", 32'(f_usage), 32'd0);
    nextCycle();

    // Mid-operation reset discards contents; first read after is the new push
    a_w_valid = 1;
    a_w_data  = 8'h11;
    nextCycle();
    a_w_data = 8'h22;
    nextCycle();
    @(negedge clk);
    checkOutput("mrst.pre.usage", 32'(a_usage), 32'd2);
    rst       = 1;
    a_w_data  = 8'h99;
    a_r_ready = 1;
    nextCycle();
    rst       = 0;
    a_w_valid = 0;
    a_r_ready = 0;
    @(negedge clk);
    checkOutput("mrst.usage", 32'(a_usage), 32'd0);
    checkOutput("mrst.ae", 32'(a_ae), 32'd1);
    checkOutput("mrst.r_valid", 32'(a_r_valid), 32'd0);
    a_w_valid = 1;
    a_w_data  = 8'h77;
    nextCycle();
    a_w_valid = 0;
    a_r_ready = 1;
    @(negedge clk);
    checkOutput("mrst.first.r_valid", 32'(a_r_valid), 32'd1);
    checkOutput("mrst.first.r_data", 32'(a_r_data), 32'h77);
    checkOutput("mrst.first.usage", 32'(a_usage), 32'd1);
    nextCycle();
    a_r_ready = 0;
    @(negedge clk);
    checkOutput("mrst.end.usage", 32'(a_usage), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
